// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma controller slice.
// Stepping mode is selected by ENIGMA_DOUBLE_STEP_EN (see enigma_stepper).
package enigma_pkg;

    localparam int unsigned LETTER_W = 5;
    typedef logic [LETTER_W-1:0] letter_t;

    // Turnover notches: Q (rotor I), E (rotor II), V (rotor III)
    localparam letter_t NOTCH_L = 5'd16;
    localparam letter_t NOTCH_M = 5'd4;
    localparam letter_t NOTCH_R = 5'd21;

    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_NOP     = 3'd0;
    localparam opcode_t OP_SET_L   = 3'd1;
    localparam opcode_t OP_SET_M   = 3'd2;
    localparam opcode_t OP_SET_R   = 3'd3;
    localparam opcode_t OP_ENCRYPT = 3'd4;
    localparam opcode_t OP_ZERO    = 3'd5;

    typedef logic [2:0] state_t;
    localparam state_t StIdle   = 3'd0;
    localparam state_t StStep   = 3'd1;
    localparam state_t StLaunch = 3'd2;
    localparam state_t StWait   = 3'd3;
    localparam state_t StOutput = 3'd4;

endpackage

// File: rtl/enigma_stepper.sv
// Combinational rotor stepping: pre-step positions in, stepped positions out.
// ENIGMA_DOUBLE_STEP_EN selects historical double step; otherwise pure odometer.
module enigma_stepper
    import enigma_pkg::*;
#(
    parameter int unsigned LW          = 5,
    parameter int unsigned NUM_LETTERS = 26
) (
    input  logic [LW-1:0] pos_l_i,
    input  logic [LW-1:0] pos_m_i,
    input  logic [LW-1:0] pos_r_i,
    output logic [LW-1:0] pos_l_o,
    output logic [LW-1:0] pos_m_o,
    output logic [LW-1:0] pos_r_o
);

    logic r_hit, m_hit, adv_m, adv_l;

    assign r_hit = (pos_r_i == LW'(NOTCH_R));
    assign m_hit = (pos_m_i == LW'(NOTCH_M));

`ifdef ENIGMA_DOUBLE_STEP_EN
    // Middle rotor sitting on its notch drags itself along with the left rotor
    assign adv_m = r_hit || m_hit;
    assign adv_l = m_hit;
`else
    assign adv_m = r_hit;
    assign adv_l = r_hit && m_hit;
`endif

    function automatic logic [LW-1:0] inc(input logic [LW-1:0] x);
        return (x == LW'(NUM_LETTERS - 1)) ? '0 : x + LW'(1);
    endfunction

    assign pos_r_o = inc(pos_r_i);
    assign pos_m_o = adv_m ? inc(pos_m_i) : pos_m_i;
    assign pos_l_o = adv_l ? inc(pos_l_i) : pos_l_i;

endmodule

// File: rtl/enigma_ctrl.sv
// Command sequencer owning rotor positions and launching the cipher datapath.
// Stepping behaviour depends on ENIGMA_DOUBLE_STEP_EN via enigma_stepper.
module enigma_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned LW          = 5,
    parameter int unsigned NUM_LETTERS = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [2:0]    cmd_op_i,
    input  logic [LW-1:0] cmd_data_i,
    output logic          dp_start_o,
    output logic [LW-1:0] dp_letter_o,
    output logic [LW-1:0] pos_l_o,
    output logic [LW-1:0] pos_m_o,
    output logic [LW-1:0] pos_r_o,
    input  logic          dp_done_i,
    input  logic [LW-1:0] dp_result_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [LW-1:0] out_letter_o,
    output logic          err_o
);

    state_t        state_q, state_d;
    logic [LW-1:0] pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
    logic [LW-1:0] letter_q, letter_d;
    logic [LW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic [LW-1:0] step_l, step_m, step_r;
    logic          operand_bad;

    enigma_stepper #(
        .LW          (LW),
        .NUM_LETTERS (NUM_LETTERS)
    ) u_stepper (
        .pos_l_i (pos_l_q),
        .pos_m_i (pos_m_q),
        .pos_r_i (pos_r_q),
        .pos_l_o (step_l),
        .pos_m_o (step_m),
        .pos_r_o (step_r)
    );

    assign operand_bad = (cmd_data_i > LW'(NUM_LETTERS - 1));

    always_comb begin
        state_d  = state_q;
        pos_l_d  = pos_l_q;
        pos_m_d  = pos_m_q;
        pos_r_d  = pos_r_q;
        letter_d = letter_q;
        out_d    = out_q;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_NOP: ;
                        OP_SET_L: begin
                            if (operand_bad) err_d = 1'b1;
                            else             pos_l_d = cmd_data_i;
                        end
                        OP_SET_M: begin
                            if (operand_bad) err_d = 1'b1;
                            else             pos_m_d = cmd_data_i;
                        end
                        OP_SET_R: begin
                            if (operand_bad) err_d = 1'b1;
                            else             pos_r_d = cmd_data_i;
                        end
                        OP_ENCRYPT: begin
                            if (operand_bad) begin
                                err_d = 1'b1;
                            end else begin
                                letter_d = cmd_data_i;
                                state_d  = StStep;
                            end
                        end
                        OP_ZERO: begin
                            pos_l_d = '0;
                            pos_m_d = '0;
                            pos_r_d = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StStep: begin
                pos_l_d = step_l;
                pos_m_d = step_m;
                pos_r_d = step_r;
                state_d = StLaunch;
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (dp_done_i) begin
                    out_d   = dp_result_i;
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pos_l_q  <= '0;
            pos_m_q  <= '0;
            pos_r_q  <= '0;
            letter_q <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_l_q  <= pos_l_d;
            pos_m_q  <= pos_m_d;
            pos_r_q  <= pos_r_d;
            letter_q <= letter_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign dp_start_o   = (state_q == StLaunch);
    assign out_valid_o  = (state_q == StOutput);
    assign dp_letter_o  = letter_q;
    assign pos_l_o      = pos_l_q;
    assign pos_m_o      = pos_m_q;
    assign pos_r_o      = pos_r_q;
    assign out_letter_o = out_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed bench for enigma_ctrl; expected positions follow ENIGMA_DOUBLE_STEP_EN.
module tb_enigma_ctrl;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [4:0] cmd_data;
    logic       dp_start, dp_done;
    logic [4:0] dp_letter, dp_result;
    logic [4:0] pos_l, pos_m, pos_r;
    logic       out_valid, out_ready, err;
    logic [4:0] out_letter;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;

    enigma_ctrl #(
        .LW          (5),
        .NUM_LETTERS (26)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_data_i   (cmd_data),
        .dp_start_o   (dp_start),
        .dp_letter_o  (dp_letter),
        .pos_l_o      (pos_l),
        .pos_m_o      (pos_m),
        .pos_r_o      (pos_r),
        .dp_done_i    (dp_done),
        .dp_result_i  (dp_result),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_letter_o (out_letter),
        .err_o        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (dp_start) starts <= starts + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input logic [4:0] el, input logic [4:0] em,
                             input logic [4:0] er);
        check(tag, 32'({pos_l, pos_m, pos_r}), 32'({el, em, er}));
    endtask

    task automatic cmd(input logic [2:0] op, input logic [4:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 5'd0;
    endtask

    // Full ENCRYPT transaction; dly extra WAIT cycles before dp_done, rdy cycles of backpressure.
    task automatic encrypt(input logic [4:0] pt, input int dly, input int rdy,
                           input logic [4:0] res, input logic [4:0] el, input logic [4:0] em,
                           input logic [4:0] er);
        int s0;
        @(negedge clk);
        check("enc_ready", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_data  = pt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 5'd0;
        s0 = starts;
        check("step_idle_outputs", 32'({cmd_ready, dp_start, out_valid}), 32'(0));
        @(negedge clk);
        check("launch_start", 32'(dp_start), 32'(1));
        check("launch_letter", 32'(dp_letter), 32'(pt));
        check_pos("launch_pos", el, em, er);
        @(negedge clk);
        for (int i = 0; i < dly; i++) begin
            check("wait_busy", 32'({cmd_ready, dp_start, out_valid}), 32'(0));
            @(negedge clk);
        end
        dp_done   = 1'b1;
        dp_result = res;
        @(negedge clk);
        dp_done   = 1'b0;
        dp_result = res + 5'd1;
        check("out_valid", 32'(out_valid), 32'(1));
        check("out_letter", 32'(out_letter), 32'(res));
        for (int i = 0; i < rdy; i++) begin
            dp_done = (i == 0);
            @(negedge clk);
            dp_done = 1'b0;
            check("out_hold", 32'({out_valid, cmd_ready, out_letter}), 32'({1'b1, 1'b0, res}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_handshake", 32'({out_valid, cmd_ready}), 32'({1'b0, 1'b1}));
        check("one_start", 32'(starts - s0), 32'(1));
        check("dp_letter_stable", 32'(dp_letter), 32'(pt));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 5'd0;
        dp_done   = 1'b0;
        dp_result = 5'd0;
        out_ready = 1'b0;
        #1;
        check("rst_ctrl", 32'({cmd_ready, dp_start, out_valid, err}), 32'(4'b1000));
        check("rst_data", 32'({dp_letter, out_letter}), 32'(0));
        check_pos("rst_pos", 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'({cmd_ready, err}), 32'(2'b10));

        cmd(3'd1, 5'd0);
        cmd(3'd2, 5'd3);
        cmd(3'd3, 5'd20);
        check_pos("set_adu", 5'd0, 5'd3, 5'd20);

        encrypt(5'd7, 0, 0, 5'd11, 5'd0, 5'd3, 5'd21);
        encrypt(5'd4, 10, 5, 5'd17, 5'd0, 5'd4, 5'd22);
`ifdef ENIGMA_DOUBLE_STEP_EN
        encrypt(5'd0, 1, 1, 5'd2, 5'd1, 5'd5, 5'd23);
        cmd(3'd3, 5'd25);
        encrypt(5'd3, 0, 0, 5'd9, 5'd1, 5'd5, 5'd0);
`else
        encrypt(5'd0, 1, 1, 5'd2, 5'd0, 5'd4, 5'd23);
        cmd(3'd3, 5'd25);
        encrypt(5'd3, 0, 0, 5'd9, 5'd0, 5'd4, 5'd0);
`endif
        // Right on V and middle on E: both modes carry into left, which wraps Z -> A
        cmd(3'd1, 5'd25);
        cmd(3'd2, 5'd4);
        cmd(3'd3, 5'd21);
        encrypt(5'd24, 2, 0, 5'd13, 5'd0, 5'd5, 5'd22);

        cmd(3'd2, 5'd26);
        check("err_set_m", 32'({err, cmd_ready}), 32'(2'b11));
        check_pos("err_set_m_pos", 5'd0, 5'd5, 5'd22);
        @(negedge clk);
        check("err_set_m_clear", 32'(err), 32'(0));
        cmd(3'd7, 5'd3);
        check("err_op7", 32'({err, cmd_ready}), 32'(2'b11));
        check_pos("err_op7_pos", 5'd0, 5'd5, 5'd22);
        @(negedge clk);
        check("err_op7_clear", 32'(err), 32'(0));
        cmd(3'd4, 5'd30);
        check("err_enc", 32'({err, cmd_ready, dp_start}), 32'(3'b110));
        @(negedge clk);
        check("err_enc_idle", 32'({err, cmd_ready, dp_start}), 32'(3'b010));

        cmd(3'd5, 5'd0);
        check_pos("zero_pos", 5'd0, 5'd0, 5'd0);
        encrypt(5'd25, 0, 0, 5'd25, 5'd0, 5'd0, 5'd1);

        // Abort while waiting on the datapath
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_data  = 5'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 5'd0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wait", 32'({cmd_ready, dp_start, out_valid}), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({cmd_ready, dp_start, out_valid, err}), 32'(4'b1000));
        check("abort_data", 32'({dp_letter, out_letter}), 32'(0));
        check_pos("abort_pos", 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dp_done   = 1'b1;
        dp_result = 5'd9;
        @(negedge clk);
        dp_done = 1'b0;
        check("late_done_ignored", 32'({out_valid, cmd_ready, out_letter}), 32'({1'b0, 1'b1, 5'd0}));
        @(negedge clk);
        check("late_done_quiet", 32'({out_valid, dp_start}), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
